// File: rtl/uart_rom_receiver.sv
// UART ROM-image receiver: 8N1 frames (8E1 when ROM_UART_PARITY_EN is defined),
// small byte FIFO, and paced indata/indata_clk strobes toward the iNES loader.
module uart_rom_receiver #(
    parameter int BIT_CLKS   = 186,
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_GAP    = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    input  logic        enable,
    output logic [7:0]  indata,
    output logic        indata_clk,
    output logic [21:0] rx_bytes,
    output logic        overrun,
    output logic        frame_err,
    output logic        busy
);

    localparam int CW = $clog2(BIT_CLKS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(MIN_GAP + 1);

    localparam logic [CW-1:0] HALF_BIT = CW'(BIT_CLKS / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(MIN_GAP);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef ROM_UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     rx_sync;
    logic [1:0]     rx_hist;
    logic           rx_s;
    logic           fall;
    logic           vote;
    logic           expire;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           frame_done;
    logic           par_err;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW:0]    wptr, rptr;
    logic           empty, full;
    logic           push, pop;
    logic [GW-1:0]  gap_cnt;

`ifdef ROM_UART_PARITY_EN
    logic           par_err_q, par_err_d;
    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    assign rx_s   = rx_sync[1];
    assign fall   = rx_hist[0] & ~rx_s;
    assign expire = (cnt_q == '0);
    // Majority of the samples taken at counter values 2, 1 and 0.
    assign vote   = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync   <= 2'b11;
            rx_hist   <= 2'b11;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
`ifdef ROM_UART_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            rx_sync   <= {rx_sync[0], rxd};
            rx_hist   <= {rx_hist[0], rx_s};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
`ifdef ROM_UART_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    // The expiry cycle itself is one bit clock, hence the BIT_CLKS-1 reload.
    always_comb begin
        state_d    = state_q;
        cnt_d      = expire ? cnt_q : cnt_q - CNT_ONE;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        frame_done = 1'b0;
`ifdef ROM_UART_PARITY_EN
        par_err_d  = par_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    cnt_d   = HALF_BIT;
                end
            end
            START: begin
                if (expire) begin
                    if (!vote) begin
                        state_d   = DATA;
                        cnt_d     = FULL_BIT;
                        bit_idx_d = '0;
`ifdef ROM_UART_PARITY_EN
                        par_err_d = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shreg_d = {vote, shreg_q[7:1]};
                    cnt_d   = FULL_BIT;
                    if (bit_idx_q == 3'd7) begin
`ifdef ROM_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef ROM_UART_PARITY_EN
            PARITY: begin
                if (expire) begin
                    par_err_d = vote ^ (^shreg_q);
                    cnt_d     = FULL_BIT;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (expire) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                    if (fall) begin
                        state_d = START;
                        cnt_d   = HALF_BIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push  = frame_done & vote & ~par_err & enable & ~full;
    assign pop   = enable & ~empty & (gap_cnt == GAP_MAX);
    assign busy  = (state_q != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= shreg_q;
        end
    end

    // Pacer, FIFO pointers, counters and sticky flags; enable low flushes the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            gap_cnt    <= GAP_MAX;
            indata     <= '0;
            indata_clk <= 1'b0;
            rx_bytes   <= '0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            indata_clk <= pop;
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (!enable) begin
                rptr <= wptr;
            end else if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            if (pop) begin
                indata  <= mem[rptr[AW-1:0]];
                gap_cnt <= '0;
                if (rx_bytes != 22'h3FFFFF) begin
                    rx_bytes <= rx_bytes + 22'd1;
                end
            end else if (gap_cnt != GAP_MAX) begin
                gap_cnt <= gap_cnt + GAP_ONE;
            end
            if (frame_done) begin
                if (!vote || par_err) begin
                    frame_err <= 1'b1;
                end else if (enable && full) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rom_receiver.sv
// Directed bench for uart_rom_receiver: one instance at default parameters and one
// small fast instance (BIT_CLKS=16, FIFO_DEPTH=2, MIN_GAP=400); honours ROM_UART_PARITY_EN.
module tb_uart_rom_receiver;

    localparam int A_BIT = 186;
    localparam int A_GAP = 50;
    localparam int B_BIT = 16;
    localparam int B_GAP = 400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rxd_a = 1'b1, rxd_b = 1'b1;
    logic        enable_a = 1'b1, enable_b = 1'b1;
    logic [7:0]  indata_a, indata_b;
    logic        indata_clk_a, indata_clk_b;
    logic [21:0] rx_bytes_a, rx_bytes_b;
    logic        overrun_a, overrun_b, frame_err_a, frame_err_b, busy_a, busy_b;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    int wide_a = 0, wide_b = 0, gapbad_a = 0, gapbad_b = 0;
    int last_a = -1, last_b = -1;
    logic prev_a = 1'b0, prev_b = 1'b0;
    logic [7:0] msg [4] = '{8'h4E, 8'h45, 8'h53, 8'h1A};

    uart_rom_receiver dut_a (
        .clk(clk), .reset(reset), .rxd(rxd_a), .enable(enable_a),
        .indata(indata_a), .indata_clk(indata_clk_a), .rx_bytes(rx_bytes_a),
        .overrun(overrun_a), .frame_err(frame_err_a), .busy(busy_a)
    );

    uart_rom_receiver #(.BIT_CLKS(B_BIT), .FIFO_DEPTH(2), .MIN_GAP(B_GAP)) dut_b (
        .clk(clk), .reset(reset), .rxd(rxd_b), .enable(enable_b),
        .indata(indata_b), .indata_clk(indata_clk_b), .rx_bytes(rx_bytes_b),
        .overrun(overrun_b), .frame_err(frame_err_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: records delivered bytes, pulse widths and inter-strobe gaps.
    always @(negedge clk) begin
        if (indata_clk_a) begin
            got_a.push_back(indata_a);
            if (prev_a) wide_a++;
            if (last_a >= 0 && (cyc - last_a) < A_GAP) gapbad_a++;
            last_a = cyc;
        end
        prev_a = indata_clk_a;
        if (indata_clk_b) begin
            got_b.push_back(indata_b);
            if (prev_b) wide_b++;
            if (last_b >= 0 && (cyc - last_b) < B_GAP) gapbad_b++;
            last_b = cyc;
        end
        prev_b = indata_clk_b;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic setLine(input bit sel, input logic v);
        if (sel) rxd_b = v;
        else rxd_a = v;
    endtask

    task automatic holdLine(input bit sel, input logic v, input int n);
        setLine(sel, v);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame: start, 8 data bits LSB first, even parity when enabled, stop.
    task automatic applyStimulus(input bit sel, input logic [7:0] data, input logic stop_bit);
        int n;
        n = sel ? B_BIT : A_BIT;
        holdLine(sel, 1'b0, n);
        for (int i = 0; i < 8; i++) holdLine(sel, data[i], n);
`ifdef ROM_UART_PARITY_EN
        holdLine(sel, ^data, n);
`endif
        holdLine(sel, stop_bit, n);
        setLine(sel, 1'b1);
    endtask

`ifdef ROM_UART_PARITY_EN
    task automatic sendParityFrame(input logic [7:0] data, input logic par_bit);
        holdLine(1'b1, 1'b0, B_BIT);
        for (int i = 0; i < 8; i++) holdLine(1'b1, data[i], B_BIT);
        holdLine(1'b1, par_bit, B_BIT);
        holdLine(1'b1, 1'b1, B_BIT);
    endtask
`endif

    task automatic resetDut();
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        got_a.delete();
        got_b.delete();
        last_a = -1;
        last_b = -1;
        waitCycles(2);
    endtask

    function automatic logic [31:0] byteAt(input bit sel, input int i);
        if (sel) return (i < got_b.size()) ? 32'(got_b[i]) : 32'hDEAD;
        return (i < got_a.size()) ? 32'(got_a[i]) : 32'hDEAD;
    endfunction

    initial begin
        resetDut();
        checkOutput("rst_indata", 32'(indata_a), 32'h0);
        checkOutput("rst_indata_clk", 32'(indata_clk_a), 32'h0);
        checkOutput("rst_rx_bytes", 32'(rx_bytes_a), 32'h0);
        checkOutput("rst_overrun", 32'(overrun_a), 32'h0);
        checkOutput("rst_frame_err", 32'(frame_err_a), 32'h0);
        checkOutput("rst_busy", 32'(busy_a), 32'h0);
        checkOutput("rst_busy_b", 32'(busy_b), 32'h0);

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, msg[i], 1'b1);
        waitCycles(100);
        checkOutput("a_count", 32'(got_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("a_byte%0d", i), byteAt(1'b0, i), 32'(msg[i]));
        checkOutput("a_rx_bytes", 32'(rx_bytes_a), 32'd4);
        checkOutput("a_overrun", 32'(overrun_a), 32'h0);
        checkOutput("a_frame_err", 32'(frame_err_a), 32'h0);
        checkOutput("a_width", 32'(wide_a), 32'h0);
        checkOutput("a_gap", 32'(gapbad_a), 32'h0);

        holdLine(1'b0, 1'b1, 2 * A_BIT);
        applyStimulus(1'b0, 8'hA5, 1'b0);
        holdLine(1'b0, 1'b1, 2 * A_BIT);
        checkOutput("ferr_flag", 32'(frame_err_a), 32'h1);
        checkOutput("ferr_no_strobe", 32'(got_a.size()), 32'd4);
        applyStimulus(1'b0, 8'h3C, 1'b1);
        waitCycles(100);
        checkOutput("ferr_next_count", 32'(got_a.size()), 32'd5);
        checkOutput("ferr_next_byte", byteAt(1'b0, 4), 32'h3C);
        checkOutput("ferr_rx_bytes", 32'(rx_bytes_a), 32'd5);

        holdLine(1'b0, 1'b0, 3);
        holdLine(1'b0, 1'b1, 10);
        checkOutput("glitch_busy_mid", 32'(busy_a), 32'h1);
        waitCycles(90);
        checkOutput("glitch_busy_end", 32'(busy_a), 32'h0);
        checkOutput("glitch_no_strobe", 32'(got_a.size()), 32'd5);
        checkOutput("glitch_overrun", 32'(overrun_a), 32'h0);

        applyStimulus(1'b1, 8'h11, 1'b1);
        applyStimulus(1'b1, 8'h22, 1'b1);
        applyStimulus(1'b1, 8'h33, 1'b1);
        enable_b = 1'b0;
        waitCycles(600);
        checkOutput("en_count_low", 32'(got_b.size()), 32'd1);
        checkOutput("en_busy_low", 32'(busy_b), 32'h0);
        checkOutput("en_rx_bytes_low", 32'(rx_bytes_b), 32'd1);
        enable_b = 1'b1;
        holdLine(1'b1, 1'b1, 2 * B_BIT);
        applyStimulus(1'b1, 8'h77, 1'b1);
        waitCycles(50);
        checkOutput("en_count_high", 32'(got_b.size()), 32'd2);
        checkOutput("en_first_after", byteAt(1'b1, 1), 32'h77);
        checkOutput("en_overrun", 32'(overrun_b), 32'h0);

        resetDut();
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 8'(i), 1'b1);
        waitCycles(2000);
        checkOutput("ovr_flag", 32'(overrun_b), 32'h1);
        checkOutput("ovr_rx_bytes_le4", 32'(rx_bytes_b <= 22'd4), 32'h1);
        checkOutput("ovr_count_match", 32'(got_b.size()), 32'(rx_bytes_b));
        for (int i = 0; i < 3; i++) checkOutput($sformatf("ovr_byte%0d", i), byteAt(1'b1, i), 32'(i + 1));
        if (got_b.size() > 3)
            checkOutput("ovr_byte3_order", 32'(got_b[3] == 8'h04 || got_b[3] == 8'h05), 32'h1);
        checkOutput("ovr_frame_err", 32'(frame_err_b), 32'h0);
        checkOutput("ovr_width", 32'(wide_b), 32'h0);
        checkOutput("ovr_gap", 32'(gapbad_b), 32'h0);

`ifdef ROM_UART_PARITY_EN
        resetDut();
        sendParityFrame(8'h03, 1'b1);
        waitCycles(50);
        checkOutput("par_bad_flag", 32'(frame_err_b), 32'h1);
        checkOutput("par_bad_no_strobe", 32'(got_b.size()), 32'd0);
        sendParityFrame(8'h03, 1'b0);
        waitCycles(50);
        checkOutput("par_good_count", 32'(got_b.size()), 32'd1);
        checkOutput("par_good_byte", byteAt(1'b1, 0), 32'h03);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
